// File: rtl/clk_div_ratio_ctrl_pkg.sv
// Shared types and constants for the divider ratio controller.
// The controller FSM state and the smallest ratio the divider can produce.
package clk_div_ctrl_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } ctrl_state_e;

   localparam int MIN_RATIO = 2;

endpackage

// File: rtl/clk_div_ratio_ctrl_if.sv
// Request handshake and divider-facing outputs of the ratio controller.
// The master modport is the requester side; the slave modport is the controller.
interface clk_div_ratio_ctrl_if #(
   parameter int WIDTH = 3
) ();

   logic             req_valid;
   logic [WIDTH-1:0] req_ratio;
   logic             req_ready;
   logic [WIDTH-1:0] div_ratio;
   logic             period_start;
   logic             upd_done;
   logic             upd_err;

   modport master (
      output req_valid, req_ratio,
      input  req_ready, div_ratio, period_start, upd_done, upd_err
   );

   modport slave (
      input  req_valid, req_ratio,
      output req_ready, div_ratio, period_start, upd_done, upd_err
   );

endinterface

// File: rtl/clk_div_ratio_ctrl_ratio_phase_cnt.sv
// Phase counter mirroring the divider's position within its output period.
// Counts 0..ratio-1, flags the last cycle, and can be forced to zero on a ratio change.
module ratio_phase_cnt #(
   parameter int WIDTH = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] ratio,
   input  logic             load_zero,
   output logic [WIDTH-1:0] phase,
   output logic             wrap
);

   logic [WIDTH-1:0] phase_cnt_q;
   logic [WIDTH-1:0] phase_cnt_d;

   // ratio is never below 2, so ratio-1 cannot underflow
   assign wrap  = (phase_cnt_q == (ratio - WIDTH'(1)));
   assign phase = phase_cnt_q;

   always_comb begin
      phase_cnt_d = phase_cnt_q + WIDTH'(1);
      if (load_zero || wrap) begin
         phase_cnt_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         phase_cnt_q <= '0;
      end else begin
         phase_cnt_q <= phase_cnt_d;
      end
   end

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// Owns the divider's ratio bus: validates change requests and applies a legal
// change only at a period boundary, so the divider never sees a mid-period switch.
module clk_div_ratio_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int WIDTH         = 3,
   parameter int DEFAULT_RATIO = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   clk_div_ratio_ctrl_if.slave  bus
);

   ctrl_state_e      state_q;
   ctrl_state_e      state_d;
   logic [WIDTH-1:0] div_ratio_q;
   logic [WIDTH-1:0] div_ratio_d;
   logic [WIDTH-1:0] pend_ratio_q;
   logic [WIDTH-1:0] pend_ratio_d;
   logic             req_ready_q;
   logic             req_ready_d;
   logic             upd_done_q;
   logic             upd_done_d;
   logic             upd_err_q;
   logic             upd_err_d;

   logic             accept;
   logic             load_zero;
   logic [WIDTH-1:0] phase;
   logic             wrap;

   ratio_phase_cnt #(
      .WIDTH (WIDTH)
   ) u_phase_cnt (
      .clock     (clock),
      .reset     (reset),
      .ratio     (div_ratio_q),
      .load_zero (load_zero),
      .phase     (phase),
      .wrap      (wrap)
   );

   assign accept = bus.req_valid && req_ready_q;

   always_comb begin
      state_d      = state_q;
      div_ratio_d  = div_ratio_q;
      pend_ratio_d = pend_ratio_q;
      upd_done_d   = 1'b0;
      upd_err_d    = 1'b0;
      load_zero    = 1'b0;
      case (state_q)
         IDLE: begin
            // A wrap coinciding with acceptance is not used; the change waits a full period
            if (accept) begin
               if (bus.req_ratio < WIDTH'(MIN_RATIO)) begin
                  upd_err_d = 1'b1;
               end else if (bus.req_ratio == div_ratio_q) begin
                  upd_done_d = 1'b1;
               end else begin
                  pend_ratio_d = bus.req_ratio;
                  state_d      = PENDING;
               end
            end
         end
         PENDING: begin
            if (wrap) begin
               div_ratio_d = pend_ratio_q;
               load_zero   = 1'b1;
               upd_done_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         div_ratio_q  <= WIDTH'(DEFAULT_RATIO);
         pend_ratio_q <= '0;
         req_ready_q  <= 1'b1;
         upd_done_q   <= 1'b0;
         upd_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_ratio_q  <= div_ratio_d;
         pend_ratio_q <= pend_ratio_d;
         req_ready_q  <= req_ready_d;
         upd_done_q   <= upd_done_d;
         upd_err_q    <= upd_err_d;
      end
   end

   assign bus.req_ready    = req_ready_q;
   assign bus.div_ratio    = div_ratio_q;
   assign bus.period_start = (phase == '0);
   assign bus.upd_done     = upd_done_q;
   assign bus.upd_err      = upd_err_q;

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Directed bench for clk_div_ratio_ctrl with WIDTH=3, DEFAULT_RATIO=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_clk_div_ratio_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   clk_div_ratio_ctrl_if #(.WIDTH(3)) bus ();

   clk_div_ratio_ctrl #(
      .WIDTH         (3),
      .DEFAULT_RATIO (2)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_ratio = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state, then period_start every 2nd cycle
      chk("rst_div", bus.div_ratio, 2);
      chk("rst_ready", bus.req_ready, 1);
      chk("rst_ps", bus.period_start, 1);
      chk("rst_done", bus.upd_done, 0);
      chk("rst_err", bus.upd_err, 0);
      tick(); chk("ps_c1", bus.period_start, 0);
      tick(); chk("ps_c2", bus.period_start, 1);
      tick(); chk("ps_c3", bus.period_start, 0);
      tick(); chk("ps_c4", bus.period_start, 1);

      // Equal-ratio request: immediate done, no disturbance of the phase
      bus.req_valid = 1'b1; bus.req_ratio = 3'd2;
      tick(); bus.req_valid = 1'b0;
      chk("eq_done", bus.upd_done, 1);
      chk("eq_err", bus.upd_err, 0);
      chk("eq_ready", bus.req_ready, 1);
      chk("eq_ps", bus.period_start, 0);
      tick();
      chk("eq_ps_next", bus.period_start, 1);
      chk("eq_done_clr", bus.upd_done, 0);

      // Request 5 at phase 0 with ratio 2: applied two cycles later
      bus.req_valid = 1'b1; bus.req_ratio = 3'd5;
      tick(); bus.req_valid = 1'b0;
      chk("r5_ready_lo", bus.req_ready, 0);
      chk("r5_div_old", bus.div_ratio, 2);
      chk("r5_done_lo", bus.upd_done, 0);
      tick();
      chk("r5_div", bus.div_ratio, 5);
      chk("r5_done", bus.upd_done, 1);
      chk("r5_ps", bus.period_start, 1);
      chk("r5_ready", bus.req_ready, 1);
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("r5_ps_spacing", bus.period_start, (k == 5) ? 1 : 0);
      end

      // Illegal ratios 1 then 0
      bus.req_valid = 1'b1; bus.req_ratio = 3'd1;
      tick();
      chk("ill1_err", bus.upd_err, 1);
      chk("ill1_done", bus.upd_done, 0);
      chk("ill1_ready", bus.req_ready, 1);
      bus.req_ratio = 3'd0;
      tick(); bus.req_valid = 1'b0;
      chk("ill0_err", bus.upd_err, 1);
      chk("ill0_div", bus.div_ratio, 5);
      tick();
      chk("ill_err_clr", bus.upd_err, 0);
      tick(); chk("ill_ps_p4", bus.period_start, 0);
      tick(); chk("ill_ps_p0", bus.period_start, 1);

      // Request 7 in the wrap cycle (phase 4 of 5): latency 6
      repeat (4) tick();
      bus.req_valid = 1'b1; bus.req_ratio = 3'd7;
      tick(); bus.req_valid = 1'b0;
      chk("wr_ready_lo", bus.req_ready, 0);
      chk("wr_ps", bus.period_start, 1);
      chk("wr_div_old", bus.div_ratio, 5);
      repeat (4) tick();
      chk("wr_div_still", bus.div_ratio, 5);
      chk("wr_done_lo", bus.upd_done, 0);
      tick();
      chk("wr_div", bus.div_ratio, 7);
      chk("wr_done", bus.upd_done, 1);
      chk("wr_ps_new", bus.period_start, 1);

      // Change to 6 with a held request for 3 behind it
      bus.req_valid = 1'b1; bus.req_ratio = 3'd6;
      tick();
      bus.req_ratio = 3'd3;
      chk("h6_ready_lo", bus.req_ready, 0);
      repeat (5) tick();
      chk("h6_div_old", bus.div_ratio, 7);
      chk("h6_ready_still", bus.req_ready, 0);
      tick();
      chk("h6_div", bus.div_ratio, 6);
      chk("h6_done", bus.upd_done, 1);
      chk("h6_ready", bus.req_ready, 1);
      tick(); bus.req_valid = 1'b0;
      chk("h3_ready_lo", bus.req_ready, 0);
      chk("h3_done_lo", bus.upd_done, 0);
      repeat (4) tick();
      chk("h3_div_old", bus.div_ratio, 6);
      tick();
      chk("h3_div", bus.div_ratio, 3);
      chk("h3_done", bus.upd_done, 1);
      chk("h3_ps", bus.period_start, 1);

      // Reset while a change to 5 is pending
      bus.req_valid = 1'b1; bus.req_ratio = 3'd5;
      tick(); bus.req_valid = 1'b0;
      chk("rp_ready_lo", bus.req_ready, 0);
      rst = 1'b1;
      tick(); rst = 1'b0;
      chk("rp_div", bus.div_ratio, 2);
      chk("rp_ready", bus.req_ready, 1);
      chk("rp_done", bus.upd_done, 0);
      chk("rp_ps", bus.period_start, 1);
      tick();
      chk("rp_done_n1", bus.upd_done, 0);
      chk("rp_div_n1", bus.div_ratio, 2);
      chk("rp_ps_n1", bus.period_start, 0);
      tick();
      chk("rp_done_n2", bus.upd_done, 0);
      chk("rp_ps_n2", bus.period_start, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
